// File: rtl/md_sequencer.sv
// Multiply/divide sequencer: fixed-latency mult/div with HI/LO ownership and D-stage stall.
// Optional MD_FLUSH_EN adds flushE to abandon an in-flight op or suppress E-stage writes.
module md_sequencer #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  mdctr,
    input  logic        start,
    input  logic        hiwrite,
    input  logic        lowrite,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    input  logic        md_useD,
`ifdef MD_FLUSH_EN
    input  logic        flushE,
`endif
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [31:0]        pend_hi, pend_hi_d;
    logic [31:0]        pend_lo, pend_lo_d;
    logic [31:0]        hi_d, lo_d;

    logic               flush;
    logic               op_legal;
    logic [CNT_W-1:0]   op_cycles;
    logic [63:0]        op_result;

    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic signed [31:0] quot_s, rem_s;
    logic [31:0]        quot_u, rem_u;
    logic               div_zero, div_ovf;

`ifdef MD_FLUSH_EN
    assign flush = flushE;
`else
    assign flush = 1'b0;
`endif

    // Datapath: full-width products and quotients, corner cases resolved in the op mux
    assign prod_s   = $signed({{32{srcA[31]}}, srcA}) * $signed({{32{srcB[31]}}, srcB});
    assign prod_u   = {32'd0, srcA} * {32'd0, srcB};
    assign div_zero = (srcB == 32'd0);
    assign div_ovf  = (srcA == 32'h8000_0000) && (srcB == 32'hFFFF_FFFF);
    assign quot_s   = $signed(srcA) / $signed(srcB);
    assign rem_s    = $signed(srcA) % $signed(srcB);
    assign quot_u   = srcA / srcB;
    assign rem_u    = srcA % srcB;

    // Op decode: legality, latency and the {hi, lo} result to park in pend
    always_comb begin
        op_legal  = 1'b0;
        op_cycles = '0;
        op_result = '0;
        case (mdctr)
            3'b001: begin
                op_legal  = 1'b1;
                op_cycles = CNT_W'(MULT_CYCLES);
                op_result = prod_s;
            end
            3'b010: begin
                op_legal  = 1'b1;
                op_cycles = CNT_W'(MULT_CYCLES);
                op_result = prod_u;
            end
            3'b011: begin
                op_legal  = 1'b1;
                op_cycles = CNT_W'(DIV_CYCLES);
                if (div_zero)     op_result = {srcA, 32'hFFFF_FFFF};
                else if (div_ovf) op_result = {32'd0, 32'h8000_0000};
                else              op_result = {rem_s, quot_s};
            end
            3'b100: begin
                op_legal  = 1'b1;
                op_cycles = CNT_W'(DIV_CYCLES);
                if (div_zero) op_result = {srcA, 32'hFFFF_FFFF};
                else          op_result = {rem_u, quot_u};
            end
            default: ;
        endcase
    end

    // Next-state / next-value logic
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        pend_hi_d = pend_hi;
        pend_lo_d = pend_lo;
        hi_d      = hi;
        lo_d      = lo;
        case (state)
            IDLE: begin
                if (!flush) begin
                    if (start && op_legal) begin
                        pend_hi_d = op_result[63:32];
                        pend_lo_d = op_result[31:0];
                        cnt_d     = op_cycles;
                        state_d   = RUN;
                    end else begin
                        if (hiwrite) hi_d = srcA;
                        if (lowrite) lo_d = srcA;
                    end
                end
            end
            RUN: begin
                if (flush) begin
                    cnt_d     = '0;
                    pend_hi_d = '0;
                    pend_lo_d = '0;
                    state_d   = IDLE;
                end else if (cnt <= CNT_W'(1)) begin
                    hi_d    = pend_hi;
                    lo_d    = pend_lo;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            pend_hi <= pend_hi_d;
            pend_lo <= pend_lo_d;
            hi      <= hi_d;
            lo      <= lo_d;
        end
    end

    assign busy = (state == RUN);

    // Same-cycle stall so a mult/div in D waits even while its predecessor is only just starting
    assign stall = md_useD & (start | busy);

endmodule

// File: tb/tb_md_sequencer.sv
// Scoreboard bench for md_sequencer: a posedge reference model pushes expected commits,
// a negedge monitor pops and compares them and checks busy/stall/HI/LO every cycle.
module tb_md_sequencer;

    localparam int unsigned MC = 5;
    localparam int unsigned DC = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  mdctr = 3'd0;
    logic        start = 1'b0;
    logic        hiwrite = 1'b0;
    logic        lowrite = 1'b0;
    logic [31:0] srcA = 32'd0;
    logic [31:0] srcB = 32'd0;
    logic        md_useD = 1'b0;
    logic        busy, stall;
    logic [31:0] hi, lo;
`ifdef MD_FLUSH_EN
    logic        flushE = 1'b0;
`endif

    md_sequencer #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk     (clk),
        .reset   (rst_n),
        .mdctr   (mdctr),
        .start   (start),
        .hiwrite (hiwrite),
        .lowrite (lowrite),
        .srcA    (srcA),
        .srcB    (srcB),
        .md_useD (md_useD),
`ifdef MD_FLUSH_EN
        .flushE  (flushE),
`endif
        .busy    (busy),
        .stall   (stall),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic straight from the ISA rules, using 64-bit integers
    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned ua = 64'(a);
        longint unsigned ub = 64'(b);
        longint          q, r;
        case (op)
            3'd1: return 64'(sa * sb);
            3'd2: return 64'(ua * ub);
            3'd3: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {32'(r), 32'(q)};
            end
            3'd4: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {32'(ua % ub), 32'(ua / ub)};
            end
            default: return 64'd0;
        endcase
    endfunction

    function automatic int op_cycles(input logic [2:0] op);
        if (op == 3'd1 || op == 3'd2) return int'(MC);
        if (op == 3'd3 || op == 3'd4) return int'(DC);
        return 0;
    endfunction

    typedef struct {
        logic [63:0] res;
        int          cycles;
    } exp_t;

    exp_t        exp_q[$];
    int          m_left = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [63:0] m_pend = 64'd0;

    // Reference model: architectural view of HI/LO and remaining busy cycles
    always @(posedge clk or negedge rst_n) begin
        logic m_flush;
        if (!rst_n) begin
            m_hi   = 32'd0;
            m_lo   = 32'd0;
            m_left = 0;
            exp_q.delete();
        end else begin
`ifdef MD_FLUSH_EN
            m_flush = flushE;
`else
            m_flush = 1'b0;
`endif
            if (m_left > 0) begin
                if (m_flush) begin
                    m_left = 0;
                    exp_q.delete();
                end else begin
                    m_left--;
                    if (m_left == 0) {m_hi, m_lo} = m_pend;
                end
            end else if (!m_flush) begin
                if (start && op_cycles(mdctr) > 0) begin
                    m_pend = ref_result(mdctr, srcA, srcB);
                    m_left = op_cycles(mdctr);
                    exp_q.push_back('{res: m_pend, cycles: m_left});
                end else begin
                    if (hiwrite) m_hi = srcA;
                    if (lowrite) m_lo = srcA;
                end
            end
        end
    end

    // Monitor: per-cycle busy/stall/HI/LO checks, queue pop on each completed operation
    logic prev_busy = 1'b0;
    int   busy_cnt = 0;
    always @(negedge clk) begin
        exp_t e;
        logic exp_busy;
        if (!rst_n) begin
            prev_busy = 1'b0;
            busy_cnt  = 0;
        end else begin
            exp_busy = (m_left > 0);
            chk("busy", 64'(busy), 64'(exp_busy));
            chk("stall", 64'(stall), 64'(md_useD & (start | exp_busy)));
            if (start && busy) begin
                failures++;
                $display("FAIL start_in_run: start=1 while busy=1 at %0t", $time);
            end
            if (!busy && !prev_busy) chk("idle_hilo", {hi, lo}, {m_hi, m_lo});
            if (busy) busy_cnt++;
            if (prev_busy && !busy) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("commit_hilo", {hi, lo}, e.res);
                    chk("busy_len", 64'(busy_cnt), 64'(e.cycles));
                end
                busy_cnt = 0;
            end
            prev_busy = busy;
        end
    end

    logic force_use = 1'b0;
    always @(posedge clk) begin
        #1 md_useD = force_use ? 1'b1 : 1'($urandom_range(0, 1));
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        mdctr = op;
        srcA  = a;
        srcB  = b;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (op_cycles(op)) @(posedge clk);
        #1;
    endtask

    task automatic move(input logic h, input logic l, input logic [31:0] a);
        srcA    = a;
        hiwrite = h;
        lowrite = l;
        @(posedge clk);
        #1 hiwrite = 1'b0;
        lowrite = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] corners[6];
        corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFE};
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
        return $urandom();
    endfunction

    initial begin
        logic [2:0] illegal[4];
        illegal = '{3'd0, 3'd5, 3'd6, 3'd7};
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_hilo", {hi, lo}, 64'd0);
        @(posedge clk);
        #1;

        force_use = 1'b1;
        issue(3'd1, 32'hFFFF_FFFE, 32'd3);
        force_use = 1'b0;
        chk("mult_neg", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFA});
        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("multu_max", {hi, lo}, {32'hFFFF_FFFE, 32'h0000_0001});
        issue(3'd3, 32'hFFFF_FFF9, 32'd2);
        chk("div_neg", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        issue(3'd4, 32'h1234, 32'd0);
        chk("divu_zero", {hi, lo}, {32'h1234, 32'hFFFF_FFFF});
        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_ovf", {hi, lo}, {32'd0, 32'h8000_0000});
        move(1'b1, 1'b0, 32'hA5A5_A5A5);
        chk("mthi", {hi, lo}, {32'hA5A5_A5A5, 32'h8000_0000});
        move(1'b0, 1'b1, 32'h5A5A_0001);
        chk("mtlo", {hi, lo}, {32'hA5A5_A5A5, 32'h5A5A_0001});
        mdctr = 3'd6;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("illegal_idle", 64'(busy), 64'd0);

`ifdef MD_FLUSH_EN
        mdctr = 3'd1;
        srcA  = 32'd7;
        srcB  = 32'd9;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 flushE = 1'b1;
        @(posedge clk);
        #1 flushE = 1'b0;
        chk("flush_busy", 64'(busy), 64'd0);
        repeat (MC + 1) @(posedge clk);
        #1 chk("flush_hilo", {hi, lo}, {32'hA5A5_A5A5, 32'h5A5A_0001});
`endif

        // Reset during busy cycle 3 of a div discards the result
        mdctr = 3'd3;
        srcA  = 32'd100;
        srcB  = 32'd7;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_hilo", {hi, lo}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (DC + 2) @(posedge clk);
        #1 chk("rst_no_commit", {hi, lo}, 64'd0);

        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 7))
                0, 1, 2, 3: issue(3'($urandom_range(1, 4)), pick(), pick());
                4: begin
                    mdctr = illegal[$urandom_range(0, 3)];
                    start = 1'b1;
                    @(posedge clk);
                    #1 start = 1'b0;
                end
                5: move(1'b1, 1'b0, pick());
                6: move(1'b0, 1'b1, pick());
                default: move(1'b1, 1'b1, pick());
            endcase
        end
        repeat (3) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/md_sequencer.md
Name: md_sequencer

Overview:
- Multiply/divide sequencer for the 5-stage pipeline.
- Accepts mult/multu/div/divu and mthi/mtlo control from the E-stage decoder, plus operands from E.
- Models fixed multi-cycle latency, owns the HI/LO architectural registers, and raises the D-stage stall for multiply/divide-class instructions while an operation is in flight.
- Sits beside the ALU in E; HI/LO feed the E-stage result mux for mfhi/mflo.

Parameters:
- MULT_CYCLES, 5: busy cycles for mult/multu, legal range 1..15.
- DIV_CYCLES, 10: busy cycles for div/divu, legal range 1..15.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- mdctr  in  3  op select: 3'b001 mult, 3'b010 multu, 3'b011 div, 3'b100 divu; any other value is no-op.
- start  in  1  E-stage instruction is mult/multu/div/divu.
- hiwrite  in  1  E-stage mthi.
- lowrite  in  1  E-stage mtlo.
- srcA  in  32  rs operand (forwarded).
- srcB  in  32  rt operand (forwarded).
- md_useD  in  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- busy  out  1  operation in flight.
- stall  out  1  freeze PC/F/D, bubble E.
- hi  out  32  HI register.
- lo  out  32  LO register.

Behaviour:
- Reset (asynchronous, reset low): hi=0, lo=0, busy=0, cnt=0, pend_hi=0, pend_lo=0, state IDLE.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, cnt counts down.
- IDLE with start=1 and a legal mdctr, at the clock edge:
  - Compute the 64-bit result into pend_hi/pend_lo.
  - Load cnt with MULT_CYCLES or DIV_CYCLES; go to RUN.
- RUN:
  - Each edge decrements cnt.
  - On the edge where cnt==1: hi<=pend_hi, lo<=pend_lo, cnt<=0, go to IDLE.
  - busy is therefore high for exactly N cycles following the start cycle.
  - New HI/LO are visible in the first cycle busy=0.
- start with an illegal mdctr: ignored, stay IDLE.
- Arithmetic:
  - mult: signed 32x32 -> 64; hi=[63:32], lo=[31:0].
  - multu: unsigned 32x32 -> 64, same split.
  - div: signed; lo=quotient truncated toward zero, remainder sign follows dividend.
  - divu: unsigned quotient/remainder.
  - Divide by zero (div or divu): lo=32'hFFFF_FFFF, hi=srcA.
  - Signed overflow, 32'h8000_0000 / 32'hFFFF_FFFF: lo=32'h8000_0000, hi=0.
- mthi/mtlo in IDLE: hi<=srcA or lo<=srcA at the edge; both flags set writes both.
- start takes priority over hiwrite/lowrite in the same cycle; the decoder never produces that combination.
- start/hiwrite/lowrite while in RUN: ignored. The pipeline guarantees this never happens; the bench flags it as an error.
- Stall rule: stall = md_useD & (start | busy). This is combinational, with no registered delay.
  - Consequence: mfhi/mflo in D never reads stale HI/LO.
  - Consequence: a back-to-back mult/div cannot collide.
- Reset low mid-operation: immediate return to IDLE; in-flight result discarded; hi/lo cleared.

Optional Feature:
- Macro: MD_FLUSH_EN.
- With the macro defined:
  - Extra port flushE, in, 1.
  - flushE=1 in RUN: next edge returns to IDLE, cnt=0, hi/lo keep their pre-op values, pend discarded.
  - flushE=1 in the same cycle as start: the op never begins.
  - flushE=1 while IDLE: no effect, and hiwrite/lowrite are also suppressed that cycle.
  - Used when an exception or interrupt kills the E-stage instruction.
- Without the macro: no flushE port; an operation always completes.

Test Plan:
- mult, srcA=32'hFFFF_FFFE (-2), srcB=3 -> busy=1 for exactly 5 cycles; then hi=32'hFFFF_FFFF, lo=32'hFFFF_FFFA.
- multu, srcA=32'hFFFF_FFFF, srcB=32'hFFFF_FFFF -> after 5 cycles hi=32'hFFFF_FFFE, lo=32'h0000_0001.
- div, srcA=-7, srcB=2 -> busy 10 cycles; lo=32'hFFFF_FFFD, hi=32'hFFFF_FFFF.
- divu, srcB=0, srcA=32'h1234 -> lo=32'hFFFF_FFFF, hi=32'h1234.
- div, 32'h8000_0000 / -1 -> lo=32'h8000_0000, hi=0.
- mult issued with md_useD=1 (mflo in D) -> stall=1 in the start cycle and all 5 busy cycles, 0 after; the mflo reads the new lo.
- mthi srcA=32'hA5A5_A5A5 in IDLE -> hi=32'hA5A5_A5A5 next cycle, lo unchanged.
- Assert reset at busy cycle 3 of a div -> busy=0, hi=lo=0 immediately, with no commit later.
- MD_FLUSH_EN: flushE at busy cycle 2 of a mult -> IDLE next edge, hi/lo retain their prior values.
